// File: rtl/a78_pkg.sv
// Shared types and constants for the A78 cartridge loader.
package a78_pkg;

  typedef enum logic [2:0] {IDLE, HDR, REPLAY, DATA, DONE} a78_state_t;

  localparam int A78_SIG_LEN = 9;
  localparam logic [8*A78_SIG_LEN-1:0] A78_SIG = "ATARI7800";

  localparam int OFS_SIG  = 1;
  localparam int OFS_SIZE = 49;
  localparam int OFS_TYPE = 53;

  // Header fields collected while the header streams past.
  typedef struct packed {
    logic        sig_ok;
    logic [31:0] size;
    logic [1:0]  type_hi;
    logic [7:0]  type_lo;
  } a78_hdr_t;

  // Signature byte idx (0 = 'A'), leftmost character sits in the MSBs.
  function automatic logic [7:0] sig_byte(input int idx);
    return A78_SIG[8*(A78_SIG_LEN-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/a78_hdr_buf.sv
// Header capture buffer: HDR_LEN x 8 RAM, one write port, one synchronous read port.
module a78_hdr_buf #(
  parameter int HDR_LEN = 128,
  parameter int AW      = $clog2(HDR_LEN)
) (
  input  logic          memclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [HDR_LEN];

  always_ff @(posedge memclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/a78_loader.sv
// Streams an A78 (or headerless) cartridge download into cart ROM, parsing the
// header into mapper flags/size and replaying the first block when no header exists.
module a78_loader
  import a78_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int HDR_LEN = 128
) (
  input  logic              memclk,
  input  logic              reset,
  input  logic              loading,
  input  logic              dl_valid,
  input  logic [7:0]        dl_data,
  output logic              dl_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [9:0]        cart_flags,
  output logic [31:0]       cart_size,
  output logic              hdr_ok,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(HDR_LEN + 1);
  localparam int AW = $clog2(HDR_LEN);

  a78_state_t      state, state_nx;
  a78_hdr_t        hdr;
  logic            loading_q, rise, acc, ack_fire, hdr_full;
  logic [CW-1:0]   cnt, rptr;
  logic [ADDR_W:0] waddr, waddr_eff;
  logic [7:0]      hb_rdata;
  int              sig_idx;

  assign rise      = loading & ~loading_q;
  assign acc       = dl_valid & dl_ready;
  assign ack_fire  = mem_we & mem_ack;
  assign hdr_full  = (cnt == CW'(HDR_LEN));
  // Address the next accept lands on: an ack in the same cycle retires the pending write.
  assign waddr_eff = waddr + (ADDR_W+1)'(ack_fire);
  assign sig_idx   = int'(cnt) - OFS_SIG;

  a78_hdr_buf #(.HDR_LEN(HDR_LEN), .AW(AW)) u_hbuf (
    .memclk (memclk),
    .we     (acc && state == HDR),
    .waddr  (cnt[AW-1:0]),
    .wdata  (dl_data),
    .raddr  (rptr[AW-1:0]),
    .rdata  (hb_rdata)
  );

  always_ff @(posedge memclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (rise) state_nx = HDR;
      HDR: begin
        if (hdr_full)      state_nx = hdr.sig_ok ? DATA : REPLAY;
        else if (!loading) state_nx = DONE;
      end
      REPLAY: if (ack_fire && rptr == CW'(HDR_LEN)) state_nx = DATA;
      DATA:   if (!loading && !mem_we) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dl_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      HDR: begin
        dl_ready = loading & ~hdr_full;
        busy     = 1'b1;
      end
      REPLAY: busy = 1'b1;
      DATA: begin
        dl_ready = loading & (~mem_we | mem_ack);
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      loading_q  <= 1'b0;
      cnt        <= '0;
      rptr       <= '0;
      waddr      <= '0;
      hdr        <= '0;
      hdr_ok     <= 1'b0;
      err        <= 1'b0;
      cart_flags <= '0;
      cart_size  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      loading_q <= loading;
      case (state)
        IDLE, DONE: if (rise) begin
          err    <= 1'b0;
          hdr_ok <= 1'b0;
          cnt    <= '0;
          rptr   <= '0;
          waddr  <= '0;
          hdr    <= '{sig_ok: 1'b1, default: '0};
        end
        HDR: begin
          if (hdr_full) begin
            if (hdr.sig_ok) begin
              hdr_ok     <= 1'b1;
              cart_flags <= {hdr.type_hi, hdr.type_lo};
              cart_size  <= hdr.size;
            end else begin
              cart_flags <= '0;
            end
          end else if (acc) begin
            cnt <= cnt + CW'(1);
            if (sig_idx >= 0 && sig_idx < A78_SIG_LEN && dl_data != sig_byte(sig_idx))
              hdr.sig_ok <= 1'b0;
            if (cnt >= CW'(OFS_SIZE) && cnt < CW'(OFS_TYPE))
              hdr.size <= {hdr.size[23:0], dl_data};
            if (cnt == CW'(OFS_TYPE))     hdr.type_hi <= dl_data[1:0];
            if (cnt == CW'(OFS_TYPE + 1)) hdr.type_lo <= dl_data;
          end else if (!loading) begin
            cart_size <= 32'(cnt);
          end
        end
        REPLAY: begin
          // Issue only from an idle bus so the synchronous read of rptr has settled.
          if (ack_fire) begin
            mem_we <= 1'b0;
            if (rptr == CW'(HDR_LEN)) waddr <= (ADDR_W+1)'(HDR_LEN);
          end else if (!mem_we && rptr != CW'(HDR_LEN)) begin
            mem_we   <= 1'b1;
            mem_addr <= ADDR_W'(rptr);
            mem_data <= hb_rdata;
            rptr     <= rptr + CW'(1);
          end
        end
        DATA: begin
          if (ack_fire) begin
            waddr  <= waddr + (ADDR_W+1)'(1);
            mem_we <= 1'b0;
          end
          if (acc) begin
            if (err || waddr_eff[ADDR_W]) begin
              err <= 1'b1;
            end else begin
              mem_we   <= 1'b1;
              mem_addr <= waddr_eff[ADDR_W-1:0];
              mem_data <= dl_data;
            end
          end
          if (!loading && !mem_we && !hdr_ok) cart_size <= 32'(waddr);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a78_loader.sv
// Scoreboard bench for a78_loader: default-width instance plus an ADDR_W=10 instance for overflow.
module tb_a78_loader;

  logic        memclk = 1'b0;
  logic        reset;
  logic [1:0]  loading;
  logic        dl_valid;
  logic [7:0]  dl_data;
  logic [1:0]  dl_ready, mem_we, mem_ack, hdr_ok, busy, err;
  logic [17:0] ma0;
  logic [9:0]  ma1;
  logic [7:0]  md0, md1;
  logic [9:0]  cf0, cf1;
  logic [31:0] cs0, cs1;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int ack_dly = 0;
  int wcnt0, wcnt1;
  logic [39:0] q0[$];
  logic [39:0] q1[$];

  always #5 memclk = ~memclk;

  a78_loader dut0 (
    .memclk(memclk), .reset(reset), .loading(loading[0]), .dl_valid(dl_valid),
    .dl_data(dl_data), .dl_ready(dl_ready[0]), .mem_addr(ma0), .mem_data(md0),
    .mem_we(mem_we[0]), .mem_ack(mem_ack[0]), .cart_flags(cf0), .cart_size(cs0),
    .hdr_ok(hdr_ok[0]), .busy(busy[0]), .err(err[0])
  );

  a78_loader #(.ADDR_W(10)) dut1 (
    .memclk(memclk), .reset(reset), .loading(loading[1]), .dl_valid(dl_valid),
    .dl_data(dl_data), .dl_ready(dl_ready[1]), .mem_addr(ma1), .mem_data(md1),
    .mem_we(mem_we[1]), .mem_ack(mem_ack[1]), .cart_flags(cf1), .cart_size(cs1),
    .hdr_ok(hdr_ok[1]), .busy(busy[1]), .err(err[1])
  );

  // Memory responder: ack arrives ack_dly cycles into each pending write.
  assign mem_ack[0] = mem_we[0] && (wcnt0 == ack_dly);
  assign mem_ack[1] = mem_we[1] && (wcnt1 == ack_dly);

  always @(posedge memclk or posedge reset) begin
    if (reset) begin
      wcnt0 <= 0;
      wcnt1 <= 0;
    end else begin
      if (mem_ack[0]) wcnt0 <= 0; else if (mem_we[0]) wcnt0 <= wcnt0 + 1;
      if (mem_ack[1]) wcnt1 <= 0; else if (mem_we[1]) wcnt1 <= wcnt1 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic mon_wr(input int s, input logic [31:0] a, input logic [7:0] d);
    logic [39:0] e;
    checks++;
    if ((s == 0 ? q0.size() : q1.size()) == 0) begin
      errors++;
      $display("FAIL unexpected_write dut%0d: got addr 0x%0h data 0x%0h, expected none", s, a, d);
    end else begin
      e = (s == 0) ? q0.pop_front() : q1.pop_front();
      if (e !== {a, d}) begin
        errors++;
        $display("FAIL write dut%0d: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                 s, a, d, e[39:8], e[7:0]);
      end
    end
  endtask

  logic        pv_we = 1'b0;
  logic [17:0] pv_a;
  logic [7:0]  pv_d;

  always @(negedge memclk) begin
    if (mem_we[0] && mem_ack[0]) mon_wr(0, 32'(ma0), md0);
    if (mem_we[1] && mem_ack[1]) mon_wr(1, 32'(ma1), md1);
    if (pv_we && mem_we[0]) begin
      chk("hold_addr", 32'(ma0), 32'(pv_a));
      chk("hold_data", 32'(md0), 32'(pv_d));
    end
    if (mem_we[0] && !mem_ack[0]) chk("ready_while_pending", 32'(dl_ready[0]), 32'd0);
    pv_we = mem_we[0] && !mem_ack[0];
    pv_a  = ma0;
    pv_d  = md0;
  end

  task automatic push(input int s, input int a, input logic [7:0] d);
    if (s == 0) q0.push_back({32'(a), d});
    else        q1.push_back({32'(a), d});
  endtask

  function automatic logic [7:0] hdr_byte(input int i);
    logic [71:0] s;
    s = "ATARI7800";
    if (i >= 1 && i <= 9) return s[8*(9-i) +: 8];
    case (i)
      0:  return 8'h03;
      49: return 8'h00;
      50: return 8'h00;
      51: return 8'h80;
      52: return 8'h00;
      53: return 8'h00;
      54: return 8'h02;
      default: return 8'(i ^ 32'hA5);
    endcase
  endfunction

  function automatic logic [7:0] dbyte(input int k);
    return 8'(k * 11 + (k >> 8));
  endfunction

  function automatic logic [7:0] img(input int i);
    if (i == 1) return 8'h00;
    return 8'(i * 37 + (i >> 7));
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    dl_valid = 1'b1;
    dl_data  = b;
    for (int t = 0; t < 2000; t++) begin
      #1;
      if (dl_ready[sel]) begin
        @(negedge memclk);
        return;
      end
      @(negedge memclk);
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout dut%0d: byte 0x%0h not accepted within 2000 cycles", sel, b);
  endtask

  task automatic start(input int s);
    sel = s;
    @(negedge memclk);
    loading[s] = 1'b1;
  endtask

  task automatic finish(input int s);
    dl_valid   = 1'b0;
    loading[s] = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge memclk);
      if (!busy[s]) break;
    end
    chk("done_not_busy", 32'(busy[s]), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    loading  = 2'b00;
    dl_valid = 1'b0;
    dl_data  = 8'h00;
    repeat (3) @(negedge memclk);
    chk("rst_we",     32'(mem_we[0]), 32'd0);
    chk("rst_ready",  32'(dl_ready[0]), 32'd0);
    reset = 1'b0;
    @(negedge memclk);
    chk("rst_addr",   32'(ma0), 32'd0);
    chk("rst_data",   32'(md0), 32'd0);
    chk("rst_flags",  32'(cf0), 32'd0);
    chk("rst_size",   cs0, 32'd0);
    chk("rst_hdr_ok", 32'(hdr_ok[0]), 32'd0);
    chk("rst_busy",   32'(busy[0]), 32'd0);
    chk("rst_err",    32'(err[0]), 32'd0);
    chk("rst_err1",   32'(err[1]), 32'd0);

    // Valid A78 header, 32 KB image
    start(0);
    for (int i = 0; i < 128; i++) send_byte(hdr_byte(i));
    chk("t1_busy", 32'(busy[0]), 32'd1);
    for (int k = 0; k < 32768; k++) begin
      push(0, k, dbyte(k));
      send_byte(dbyte(k));
    end
    finish(0);
    chk("t1_hdr_ok",  32'(hdr_ok[0]), 32'd1);
    chk("t1_flags",   32'(cf0), 32'h002);
    chk("t1_size",    cs0, 32'h8000);
    chk("t1_err",     32'(err[0]), 32'd0);
    chk("t1_drained", q0.size(), 32'd0);

    // Headerless 16 KB image, header block replayed
    start(0);
    for (int i = 0; i < 16384; i++) begin
      push(0, i, img(i));
      send_byte(img(i));
    end
    finish(0);
    chk("t2_hdr_ok",  32'(hdr_ok[0]), 32'd0);
    chk("t2_flags",   32'(cf0), 32'd0);
    chk("t2_size",    cs0, 32'h4000);
    chk("t2_err",     32'(err[0]), 32'd0);
    chk("t2_drained", q0.size(), 32'd0);

    // Slow memory: ack 3 cycles late on every write, including replay
    ack_dly = 3;
    start(0);
    for (int i = 0; i < 200; i++) begin
      push(0, i, img(i));
      send_byte(img(i));
    end
    finish(0);
    chk("t3_size",    cs0, 32'd200);
    chk("t3_drained", q0.size(), 32'd0);
    ack_dly = 0;

    // Overflow on the 10-bit instance: the 1025th byte is drained without a write
    start(1);
    for (int i = 0; i < 1025; i++) begin
      if (i < 1024) push(1, i, img(i));
      send_byte(img(i));
    end
    finish(1);
    chk("t4_err",     32'(err[1]), 32'd1);
    chk("t4_size",    cs1, 32'd1024);
    chk("t4_hdr_ok",  32'(hdr_ok[1]), 32'd0);
    chk("t4_drained", q1.size(), 32'd0);

    // Short file: loading drops mid-header
    start(0);
    for (int i = 0; i < 60; i++) send_byte(hdr_byte(i));
    finish(0);
    chk("t5_hdr_ok", 32'(hdr_ok[0]), 32'd0);
    chk("t5_size",   cs0, 32'd60);
    chk("t5_err",    32'(err[0]), 32'd0);

    // Reset mid-DATA with a write pending, then a clean reload
    ack_dly = 3;
    start(0);
    for (int i = 0; i < 128; i++) send_byte(hdr_byte(i));
    for (int k = 0; k < 8; k++) begin
      push(0, k, dbyte(k));
      send_byte(dbyte(k));
    end
    chk("t6_we_pending", 32'(mem_we[0]), 32'd1);
    chk("t6_q_pending",  q0.size(), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_we",     32'(mem_we[0]), 32'd0);
    chk("t6_rst_ready",  32'(dl_ready[0]), 32'd0);
    chk("t6_rst_addr",   32'(ma0), 32'd0);
    chk("t6_rst_hdr_ok", 32'(hdr_ok[0]), 32'd0);
    chk("t6_rst_flags",  32'(cf0), 32'd0);
    chk("t6_rst_size",   cs0, 32'd0);
    chk("t6_rst_busy",   32'(busy[0]), 32'd0);
    q0.delete();
    dl_valid   = 1'b0;
    loading[0] = 1'b0;
    ack_dly    = 0;
    @(negedge memclk);
    reset = 1'b0;
    start(0);
    for (int i = 0; i < 128; i++) send_byte(hdr_byte(i));
    for (int k = 0; k < 256; k++) begin
      push(0, k, dbyte(k));
      send_byte(dbyte(k));
    end
    finish(0);
    chk("t6_hdr_ok",  32'(hdr_ok[0]), 32'd1);
    chk("t6_flags",   32'(cf0), 32'h002);
    chk("t6_size",    cs0, 32'h8000);
    chk("t6_err",     32'(err[0]), 32'd0);
    chk("t6_drained", q0.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
